// File: rtl/packet_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// packet_sender: serializes OUT tokens / DATA0 packets LSB-first with CRC.
// Optional macro PKT_SENDER_CRC_INJECT_EN adds crc_inject.   Rev 1.0
// ---------------------------------------------------------------------------
module packet_sender #(
  parameter int PAYLOAD_BITS = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    send_OUT,
  input  logic                    send_DATA0,
  input  logic [6:0]              addr,
  input  logic [3:0]              endp,
  input  logic [PAYLOAD_BITS-1:0] data,
`ifdef PKT_SENDER_CRC_INJECT_EN
  input  logic                    crc_inject,
`endif
  output logic                    bit_out,
  output logic                    bit_valid,
  input  logic                    bit_ready,
  output logic                    pkt_start,
  output logic                    pkt_end,
  output logic                    sent,
  output logic                    busy,
  output logic                    req_err
);

  // Body shifter must also hold the 11-bit token body when the payload is narrow.
  localparam int         BODY_W          = (PAYLOAD_BITS > 11) ? PAYLOAD_BITS : 11;
  localparam logic [7:0] TOKEN_BODY_LAST = 8'd10;
  localparam logic [7:0] DATA_BODY_LAST  = 8'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_BODY, S_CRC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        pid_q, pid_d;
  logic [BODY_W-1:0] body_q, body_d;
  logic [15:0]       crc_q, crc_d;
  logic              is_data_q, is_data_d;
  logic              inject_q, inject_d;
  logic              req_err_q, req_err_d;

  logic              req, adv, crc_fb, crc_bit;
  logic [7:0]        body_last, crc_last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pid_d     = pid_q;
    body_d    = body_q;
    crc_d     = crc_q;
    is_data_d = is_data_q;
    inject_d  = inject_q;
    req_err_d = 1'b0;
    bit_out   = 1'b0;
    pkt_start = 1'b0;
    pkt_end   = 1'b0;

    req       = send_OUT | send_DATA0;
    bit_valid = (state_q == S_PID) || (state_q == S_BODY) || (state_q == S_CRC);
    adv       = bit_valid & bit_ready;
    body_last = is_data_q ? DATA_BODY_LAST : TOKEN_BODY_LAST;
    crc_last  = is_data_q ? 8'd15 : 8'd4;
    crc_fb    = body_q[0] ^ (is_data_q ? crc_q[15] : crc_q[4]);
    crc_bit   = is_data_q ? ~crc_q[15] : ~crc_q[4];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req) begin
          // OUT wins a simultaneous request; the DATA0 half is reported as dropped.
          state_d   = S_PID;
          is_data_d = ~send_OUT;
          pid_d     = send_OUT ? 8'hE1 : 8'hC3;
          body_d    = send_OUT ? BODY_W'({endp, addr}) : BODY_W'(data);
          crc_d     = 16'hFFFF;
          req_err_d = send_OUT & send_DATA0;
`ifdef PKT_SENDER_CRC_INJECT_EN
          inject_d  = crc_inject;
`else
          inject_d  = 1'b0;
`endif
        end
      end
      S_PID: begin
        bit_out   = pid_q[0];
        pkt_start = (cnt_q == 8'd0);
        req_err_d = req;
        if (adv) begin
          pid_d = {1'b0, pid_q[7:1]};
          if (cnt_q == 8'd7) state_d = S_BODY;
        end
      end
      S_BODY: begin
        bit_out   = body_q[0];
        req_err_d = req;
        if (adv) begin
          body_d = {1'b0, body_q[BODY_W-1:1]};
          if (is_data_q) crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
          else           crc_d = {11'd0, crc_q[3:0], 1'b0} ^ (crc_fb ? 16'h0005 : 16'h0000);
          if (cnt_q == body_last) state_d = S_CRC;
        end
      end
      S_CRC: begin
        pkt_end   = (cnt_q == crc_last);
        bit_out   = pkt_end ? (crc_bit ^ inject_q) : crc_bit;
        req_err_d = req;
        if (adv) begin
          // Remainder goes out MSB first, so shift the register toward its MSB.
          crc_d = {crc_q[14:0], 1'b0};
          if (pkt_end) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
    else if (adv)           cnt_d = cnt_q + 8'd1;

    sent    = (state_q == S_DONE);
    busy    = (state_q != S_IDLE);
    req_err = req_err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      pid_q     <= 8'd0;
      body_q    <= '0;
      crc_q     <= 16'd0;
      is_data_q <= 1'b0;
      inject_q  <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pid_q     <= pid_d;
      body_q    <= body_d;
      crc_q     <= crc_d;
      is_data_q <= is_data_d;
      inject_q  <= inject_d;
      req_err_q <= req_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_packet_sender: directed scoreboard bench for packet_sender.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_packet_sender;
  localparam int PAYLOAD_BITS = 64;

  logic                    clock = 1'b0;
  logic                    reset, send_OUT, send_DATA0, bit_ready;
  logic [6:0]              addr;
  logic [3:0]              endp;
  logic [PAYLOAD_BITS-1:0] data;
  logic                    bit_out, bit_valid, pkt_start, pkt_end, sent, busy, req_err;
`ifdef PKT_SENDER_CRC_INJECT_EN
  logic                    crc_inject;
`endif

  typedef struct packed {logic b; logic s; logic e;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc_n = 0, sent_cnt = 0, err_cnt = 0, bits_acc = 0, last_sent = 0;

  always #5 clock = ~clock;

  packet_sender #(.PAYLOAD_BITS(PAYLOAD_BITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .send_OUT   (send_OUT),
    .send_DATA0 (send_DATA0),
    .addr       (addr),
    .endp       (endp),
    .data       (data),
`ifdef PKT_SENDER_CRC_INJECT_EN
    .crc_inject (crc_inject),
`endif
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .pkt_start  (pkt_start),
    .pkt_end    (pkt_end),
    .sent       (sent),
    .busy       (busy),
    .req_err    (req_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {25'd0, bit_out, bit_valid, pkt_start, pkt_end, sent, busy, req_err}, 32'd0);
  endtask

  task automatic push_bit(input logic b, input logic s, input logic e);
    exp_t x;
    x.b = b; x.s = s; x.e = e;
    sb.push_back(x);
  endtask

  function automatic logic [4:0] crc5(input logic [10:0] bits);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = bits[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16(input logic [PAYLOAD_BITS-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < PAYLOAD_BITS; i++) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return ~c;
  endfunction

  task automatic push_token(input logic [6:0] a, input logic [3:0] e, input logic [4:0] crc);
    logic [7:0]  pid;
    logic [10:0] body;
    pid  = 8'hE1;
    body = {e, a};
    for (int i = 0; i < 8; i++)  push_bit(pid[i], i == 0, 1'b0);
    for (int i = 0; i < 11; i++) push_bit(body[i], 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) push_bit(crc[i], 1'b0, i == 0);
  endtask

  task automatic push_data(input logic [PAYLOAD_BITS-1:0] d, input logic inj);
    logic [7:0]  pid;
    logic [15:0] crc;
    pid = 8'hC3;
    crc = crc16(d);
    if (inj) crc[0] = ~crc[0];
    for (int i = 0; i < 8; i++)            push_bit(pid[i], i == 0, 1'b0);
    for (int i = 0; i < PAYLOAD_BITS; i++) push_bit(d[i], 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--)          push_bit(crc[i], 1'b0, i == 0);
  endtask

  // One clock: sample mid-cycle, score accepted bits, then step past the edge.
  task automatic cyc();
    exp_t e;
    @(negedge clock);
    if (sent) begin sent_cnt++; last_sent = cyc_n; end
    if (req_err) err_cnt++;
    if (bit_valid) begin
      if (sb.size() == 0) chk("unexpected_bit", sb.size(), 1);
      else begin
        e = sb[0];
        if (bit_ready) begin
          chk("bit", {29'd0, bit_out, pkt_start, pkt_end}, {29'd0, e.b, e.s, e.e});
          void'(sb.pop_front());
          bits_acc++;
        end else begin
          chk("stall_bit", {29'd0, bit_out, pkt_start, pkt_end}, {29'd0, e.b, e.s, e.e});
        end
      end
    end
    @(posedge clock);
    cyc_n++;
    #1;
  endtask

  task automatic run_pkt(input int bound);
    int s;
    s = sent_cnt;
    for (int i = 0; i < bound && sent_cnt == s; i++) cyc();
    chk("pkt_done", sent_cnt - s, 1);
    cyc();
    cyc();
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int k, s0, e0, b0, st5, ste;
    logic [PAYLOAD_BITS-1:0] d;

    reset = 1'b1; send_OUT = 1'b0; send_DATA0 = 1'b0; bit_ready = 1'b1;
    addr = '0; endp = '0; data = '0;
`ifdef PKT_SENDER_CRC_INJECT_EN
    crc_inject = 1'b0;
`endif
    cyc();
    cyc();
    chk_idle("reset_state");
    reset = 1'b0;
    cyc();

    // Reference OUT token with its known CRC5.
    s0 = sent_cnt; k = cyc_n;
    push_token(7'h15, 4'hE, 5'b10111);
    addr = 7'h15; endp = 4'hE; send_OUT = 1'b1;
    cyc();
    send_OUT = 1'b0;
    run_pkt(60);
    chk("out_sent_latency", last_sent - k, 25);
    chk("out_sent_once", sent_cnt - s0, 1);

    // DATA0 with counting payload.
    s0 = sent_cnt; k = cyc_n;
    d = 64'h0706050403020100;
    push_data(d, 1'b0);
    data = d; send_DATA0 = 1'b1;
    cyc();
    send_DATA0 = 1'b0;
    run_pkt(150);
    chk("data_sent_latency", last_sent - k, 89);
    chk("data_sent_once", sent_cnt - s0, 1);

    // Stalls: 3 cycles at bit 5, 2 cycles at the last CRC bit.
    s0 = sent_cnt; k = cyc_n; b0 = bits_acc; st5 = 0; ste = 0;
    push_token(7'h3A, 4'h5, crc5({4'h5, 7'h3A}));
    addr = 7'h3A; endp = 4'h5; send_OUT = 1'b1;
    cyc();
    send_OUT = 1'b0;
    for (int i = 0; i < 80 && sent_cnt == s0; i++) begin
      if (bits_acc - b0 == 5 && st5 < 3)       begin bit_ready = 1'b0; st5++; end
      else if (bits_acc - b0 == 23 && ste < 2) begin bit_ready = 1'b0; ste++; end
      else bit_ready = 1'b1;
      cyc();
    end
    bit_ready = 1'b1;
    chk("stall_sent_latency", last_sent - k, 30);
    chk("stall_len", bits_acc - b0, 24);
    cyc();
    cyc();
    chk("stall_sb_empty", sb.size(), 0);

    // DATA0 requested in the very cycle sent pulses.
    s0 = sent_cnt; e0 = err_cnt; k = cyc_n;
    push_token(7'h01, 4'h1, crc5({4'h1, 7'h01}));
    addr = 7'h01; endp = 4'h1; send_OUT = 1'b1;
    cyc();
    send_OUT = 1'b0;
    for (int i = 0; i < 40 && cyc_n < k + 25; i++) cyc();
    d = {$urandom, $urandom};
    push_data(d, 1'b0);
    data = d; send_DATA0 = 1'b1;
    cyc();
    send_DATA0 = 1'b0;
    chk("b2b_sent_cycle", last_sent - k, 25);
    chk("b2b_start", {30'd0, bit_valid, pkt_start}, 32'd3);
    run_pkt(120);
    chk("b2b_sent_total", sent_cnt - s0, 2);
    chk("b2b_no_err", err_cnt - e0, 0);

    // send_OUT during a DATA0 body is dropped.
    s0 = sent_cnt;
    d = {$urandom, $urandom};
    push_data(d, 1'b0);
    data = d; send_DATA0 = 1'b1;
    cyc();
    send_DATA0 = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    e0 = err_cnt;
    addr = 7'h55; endp = 4'hA; send_OUT = 1'b1;
    cyc();
    send_OUT = 1'b0;
    cyc();
    chk("busy_req_err", err_cnt - e0, 1);
    run_pkt(120);
    chk("busy_sent_once", sent_cnt - s0, 1);

    // Simultaneous requests from IDLE: token only.
    s0 = sent_cnt; e0 = err_cnt;
    push_token(7'h2B, 4'h3, crc5({4'h3, 7'h2B}));
    addr = 7'h2B; endp = 4'h3; data = {$urandom, $urandom};
    send_OUT = 1'b1; send_DATA0 = 1'b1;
    cyc();
    send_OUT = 1'b0; send_DATA0 = 1'b0;
    cyc();
    chk("both_req_err", err_cnt - e0, 1);
    run_pkt(60);
    for (int i = 0; i < 4; i++) cyc();
    chk("both_sent_once", sent_cnt - s0, 1);
    chk("both_idle", {31'd0, busy}, 32'd0);

    // Reset at DATA0 bit 40.
    s0 = sent_cnt; b0 = bits_acc;
    d = {$urandom, $urandom};
    push_data(d, 1'b0);
    data = d; send_DATA0 = 1'b1;
    cyc();
    send_DATA0 = 1'b0;
    for (int i = 0; i < 100 && bits_acc - b0 < 40; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    chk_idle("reset_mid_pkt");
    for (int i = 0; i < 4; i++) cyc();
    chk("reset_no_sent", sent_cnt - s0, 0);

    s0 = sent_cnt; k = cyc_n;
    push_token(7'h7F, 4'hF, crc5({4'hF, 7'h7F}));
    addr = 7'h7F; endp = 4'hF; send_OUT = 1'b1;
    cyc();
    send_OUT = 1'b0;
    run_pkt(60);
    chk("post_reset_latency", last_sent - k, 25);

`ifdef PKT_SENDER_CRC_INJECT_EN
    // Injected CRC error: only the last CRC bit differs from golden.
    s0 = sent_cnt;
    d = 64'h0706050403020100;
    push_data(d, 1'b1);
    data = d; crc_inject = 1'b1; send_DATA0 = 1'b1;
    cyc();
    send_DATA0 = 1'b0; crc_inject = 1'b0;
    run_pkt(150);
    chk("inject_sent_once", sent_cnt - s0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packet_sender.md
Name: packet_sender

Overview:
- Host-side packet serializer directly downstream of the OUT transaction FSM.
- On a one-cycle `send_OUT` or `send_DATA0` request it latches its fields, builds the packet and shifts it out LSB-first, one bit per accepted cycle, to the bit-stuffer/NRZI stage.
  - OUT token: PID, ADDR, ENDP, CRC5.
  - DATA0: PID, payload, CRC16.
- Pulses `sent` when the last bit has been accepted.
- SYNC and EOP are added downstream.

Parameters:
- PAYLOAD_BITS, 64, DATA0 payload width; must be a multiple of 8, minimum 8.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- send_OUT  input  1  one-cycle request: send OUT token
- send_DATA0  input  1  one-cycle request: send DATA0 packet
- addr  input  7  device address, sampled on accept
- endp  input  4  endpoint number, sampled on accept
- data  input  PAYLOAD_BITS  payload, sampled on accept; bit 0 is sent first
- bit_out  output  1  current serial bit
- bit_valid  output  1  bit_out holds a valid bit
- bit_ready  input  1  downstream accepts bit_out this cycle; low = stall for a stuffed bit
- pkt_start  output  1  high with the first bit (PID bit 0) while bit_valid
- pkt_end  output  1  high with the last CRC bit while bit_valid
- sent  output  1  one-cycle pulse: packet fully accepted
- busy  output  1  high from accept until the cycle sent pulses (inclusive)
- req_err  output  1  one-cycle pulse: request dropped

Behaviour:
- Reset (synchronous, active-high): state IDLE; bit counter 0; shift and CRC registers cleared. All outputs 0 (bit_out, bit_valid, pkt_start, pkt_end, sent, busy, req_err).
- States: IDLE, PID, BODY, CRC, DONE.
- Accept:
  - A request is accepted in IDLE or DONE.
  - addr, endp and data are latched that cycle.
  - Next state is PID; busy rises the next cycle.
  - First bit_valid appears the cycle after accept (latency 1).
- Acceptance in DONE is mandatory: the upstream FSM issues send_DATA0 in the same cycle it sees sent.
- PID byte:
  - OUT = 8'hE1; DATA0 = 8'hC3 (PID nibble in bits 3:0, complement in 7:4).
  - 8 bits, LSB first.
- BODY:
  - Token: addr[0..6], then endp[0..3] (11 bits).
  - DATA0: data[0..PAYLOAD_BITS-1].
- CRC:
  - Token CRC5: poly x^5+x^2+1, init 5'b11111, computed over the BODY bits in send order. The remainder is inverted and sent MSB first.
  - DATA0 CRC16: poly x^16+x^15+x^2+1, init 16'hFFFF, otherwise handled as for CRC5.
  - The CRC updates only on accepted BODY bits.
- Packet lengths: token 24 bits; DATA0 PAYLOAD_BITS+24 bits (88 at default).
- Handshake:
  - A bit advances only when bit_valid && bit_ready.
  - While bit_ready=0, bit_out, pkt_start and pkt_end are held stable.
  - There is no limit on stall length.
- Completion: the cycle after the last bit is accepted, state is DONE and sent=1 for exactly 1 cycle. From DONE, return to IDLE unless a new request is accepted.
- Request errors:
  - A request while in PID, BODY or CRC is ignored (no effect on the packet in flight) and req_err pulses the next cycle.
  - send_OUT and send_DATA0 both high on accept: OUT is sent, DATA0 is dropped, req_err pulses.
- Counter: 8 bits; no wrap within a packet; cleared on every state change.
- Reset asserted mid-packet: abort immediately, no sent pulse, and bit_valid=0 the next cycle.

Optional Feature:
- Macro: PKT_SENDER_CRC_INJECT_EN.
- Defined:
  - Adds input port crc_inject (1 bit), sampled on accept.
  - If set, bit 0 of the transmitted (inverted) CRC is flipped; all other bits are unchanged.
  - Used to exercise receiver CRC-fail and timeout/retry paths.
- Undefined: the port does not exist and the CRC is always correct.

Test Plan:
- send_OUT with addr=7'h15, endp=4'hE, bit_ready=1:
  - 24 bits = E1 LSB-first, addr/endp bits, CRC5 = 5'b10111.
  - pkt_start on bit 0 and pkt_end on bit 23.
  - sent pulses on cycle 25 after accept.
- send_DATA0 with data=64'h0706050403020100:
  - 88 bits: PID C3, payload LSB-first, CRC16 matching the bit-serial software model.
  - sent exactly once.
- bit_ready held low 3 cycles at bit 5 and 2 cycles at the last CRC bit:
  - Output bits are held stable during each stall.
  - Total length is unchanged and sent is delayed by 5 cycles.
- send_DATA0 asserted in the same cycle as sent from an OUT token:
  - Accepted; DATA0 bit 0 appears the next cycle with pkt_start=1.
- send_OUT during a DATA0 body, and send_OUT plus send_DATA0 together from IDLE:
  - req_err pulses in both cases.
  - The in-flight packet is unaltered.
  - Only the OUT token is sent for the simultaneous request.
- Reset asserted at DATA0 bit 40:
  - Next cycle all outputs are 0 and state is IDLE, with no sent pulse.
  - A following send_OUT produces a correct token.
  - With PKT_SENDER_CRC_INJECT_EN defined and crc_inject=1: the last CRC bit is inverted versus the golden value.
